// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard scoreboard beside the ID stage. Each post-ID stage has a shadow slot
// recording the register it will write. A source operand that matches a slot
// either stalls the front end or is forwarded from that slot.

// Compares both ID sources against one shadow slot.
module hazard_slot_cmp #(
  parameter int AW = 3
) (
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic [AW-1:0] slot_dest,
  input  logic          slot_vld,
  output logic          hit1,
  output logic          hit2
);
  // Register 0 is hard-wired zero, so it can never carry a hazard.
  assign hit1 = slot_vld && (src1 != '0) && (slot_dest == src1);
  assign hit2 = slot_vld && (src2 != '0) && (slot_dest == src2);
endmodule

module pipeline_hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 3,
  parameter int PIPE_DEPTH     = 3,
  parameter int FWD_EN         = 0,
  parameter int CNT_WIDTH      = 16,
  localparam int FWD_W         = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_src1,
  input  logic [REG_ADDR_WIDTH-1:0] id_src2,
  input  logic [REG_ADDR_WIDTH-1:0] id_dest,
  input  logic                      id_dest_we,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic                      pipeline_stall_n,
  output logic [FWD_W-1:0]          fwd_sel1,
  output logic [FWD_W-1:0]          fwd_sel2,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  // Slot k sits at index k (1 = EX ... PIPE_DEPTH = WB).
  logic [PIPE_DEPTH:1]                     vld_pipe;
  logic [PIPE_DEPTH:1][REG_ADDR_WIDTH-1:0] dest_pipe;
  // Only the EX slot's load flag matters: load data is forwardable from slot 2
  // onward, so older slots never need it.
  logic                                    ld1;

  logic [PIPE_DEPTH:1] hit1, hit2;
  logic [FWD_W-1:0]    young1, young2;
  logic                stall_raw, stall, alloc;

  generate
    for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_slot
      hazard_slot_cmp #(.AW(REG_ADDR_WIDTH)) u_cmp (
        .src1      (id_src1),
        .src2      (id_src2),
        .slot_dest (dest_pipe[k]),
        .slot_vld  (vld_pipe[k]),
        .hit1      (hit1[k]),
        .hit2      (hit2[k])
      );
    end
  endgenerate

  // Youngest matching producer per operand: scan oldest to youngest so the
  // lowest slot index is the one left standing.
  always_comb begin
    young1 = '0;
    young2 = '0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (hit1[k]) young1 = FWD_W'(k);
      if (hit2[k]) young2 = FWD_W'(k);
    end
  end

  // Hazard decision. With forwarding only a load still in EX has no data yet;
  // since slot 1 is the youngest possible, a hit there is always the youngest.
  always_comb begin
    if (FWD_EN != 0) stall_raw = ld1 && (hit1[1] || hit2[1]);
    else             stall_raw = (|hit1) || (|hit2);
    // A flushed instruction is dead and must not hold the front end.
    stall = !rst && id_valid && !flush && stall_raw;
    alloc = id_valid && id_dest_we && (id_dest != '0) && !stall && !flush;
  end

  // Output drive; everything is quiet under reset or with an empty ID stage.
  always_comb begin
    pipeline_stall_n = !stall;
    fwd_sel1         = '0;
    fwd_sel2         = '0;
    if (!rst && id_valid && (FWD_EN != 0)) begin
      fwd_sel1 = young1;
      fwd_sel2 = young2;
    end
  end

  // Shadow pipeline: advance every cycle, insert the ID write or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      dest_pipe <= '0;
      ld1       <= 1'b0;
    end else begin
      for (int k = PIPE_DEPTH; k >= 2; k--) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        dest_pipe[k] <= dest_pipe[k-1];
      end
      vld_pipe[1]  <= alloc;
      dest_pipe[1] <= id_dest;
      ld1          <= alloc && id_is_load;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst)                              stall_cycles <= '0;
    else if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Bench for the hazard scoreboard: stall-only, forwarding and a 2-bit-counter
// instance share one input stream; each is checked against a slot-list model.
module tb_pipeline_hazard_scoreboard;
  localparam int AW = 3;
  localparam int D  = 3;
  localparam int FW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, id_dest_we, id_is_load, flush;
  logic [AW-1:0] id_src1, id_src2, id_dest;
  logic          sn  [3];
  logic [FW-1:0] fs1 [3];
  logic [FW-1:0] fs2 [3];
  logic [15:0]   cnt0, cnt1;
  logic [1:0]    cnt2;

  pipeline_hazard_scoreboard #(.FWD_EN(0)) u_stall (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_dest(id_dest), .id_dest_we(id_dest_we), .id_is_load(id_is_load), .flush(flush),
    .pipeline_stall_n(sn[0]), .fwd_sel1(fs1[0]), .fwd_sel2(fs2[0]), .stall_cycles(cnt0));
  pipeline_hazard_scoreboard #(.FWD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_dest(id_dest), .id_dest_we(id_dest_we), .id_is_load(id_is_load), .flush(flush),
    .pipeline_stall_n(sn[1]), .fwd_sel1(fs1[1]), .fwd_sel2(fs2[1]), .stall_cycles(cnt1));
  pipeline_hazard_scoreboard #(.FWD_EN(0), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_dest(id_dest), .id_dest_we(id_dest_we), .id_is_load(id_is_load), .flush(flush),
    .pipeline_stall_n(sn[2]), .fwd_sel1(fs1[2]), .fwd_sel2(fs2[2]), .stall_cycles(cnt2));

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each instance holds a list of in-flight writes, youngest first.
  int  mode   [3] = '{0, 1, 0};
  int  cmax   [3] = '{65535, 65535, 3};
  bit  mv     [3][1:D];
  int  md     [3][1:D];
  bit  ml     [3][1:D];
  int  mc     [3];
  bit  msn    [3];

  function automatic int youngest(input int i, input int src);
    if (src == 0) return 0;
    for (int k = 1; k <= D; k++)
      if (mv[i][k] && md[i][k] == src) return k;
    return 0;
  endfunction

  function automatic logic [31:0] cnt_of(input int i);
    if (i == 0) return 32'(cnt0);
    if (i == 1) return 32'(cnt1);
    return 32'(cnt2);
  endfunction

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      bit s;
      int f1, f2, y1, y2;
      s = 1'b1; f1 = 0; f2 = 0;
      if (!rst && id_valid) begin
        y1 = youngest(i, int'(id_src1));
        y2 = youngest(i, int'(id_src2));
        if (mode[i] == 0) s = !(y1 != 0 || y2 != 0);
        else begin
          f1 = y1; f2 = y2;
          s = !((y1 == 1 || y2 == 1) && ml[i][1]);
        end
        if (flush) s = 1'b1;
      end
      msn[i] = s;
      chk($sformatf("model_stall_n[%0d]", i), 32'(sn[i]), 32'(s));
      chk($sformatf("model_sel1[%0d]", i), 32'(fs1[i]), 32'(f1));
      chk($sformatf("model_sel2[%0d]", i), 32'(fs2[i]), 32'(f2));
      if (!rst) chk($sformatf("model_cnt[%0d]", i), cnt_of(i), 32'(mc[i]));
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int k = 1; k <= D; k++) begin mv[i][k] = 0; md[i][k] = 0; ml[i][k] = 0; end
        mc[i] = 0;
      end else begin
        for (int k = D; k >= 2; k--) begin
          mv[i][k] = mv[i][k-1]; md[i][k] = md[i][k-1]; ml[i][k] = ml[i][k-1];
        end
        mv[i][1] = id_valid && id_dest_we && id_dest != 0 && msn[i] && !flush;
        md[i][1] = int'(id_dest);
        ml[i][1] = id_is_load;
        if (!msn[i] && mc[i] < cmax[i]) mc[i]++;
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input int s1, input int s2, input int d,
                       input bit we, input bit ld, input bit fl);
    rst = r; id_valid = v; id_src1 = AW'(s1); id_src2 = AW'(s2);
    id_dest = AW'(d); id_dest_we = we; id_is_load = ld; flush = fl;
  endtask

  typedef struct {
    bit rst, v; int s1, s2, d; bit we, ld, fl;
    bit e_sn0, e_sn1; int e_f1, e_f2;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit r, input bit v, input int s1, input int s2, input int d,
                              input bit we, input bit ld, input bit fl,
                              input bit e0, input bit e1, input int f1, input int f2);
    vec_t t;
    t.rst = r; t.v = v; t.s1 = s1; t.s2 = s2; t.d = d; t.we = we; t.ld = ld; t.fl = fl;
    t.e_sn0 = e0; t.e_sn1 = e1; t.e_f1 = f1; t.e_f2 = f2;
    tbl.push_back(t);
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    //   rst v  s1 s2 d we ld fl  sn0 sn1 f1 f2
    add(1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);   // clear
    add(0, 1, 0, 0, 3, 1, 0, 0,  1, 1, 0, 0);   // preload r3
    add(1, 1, 3, 0, 0, 0, 0, 0,  1, 1, 0, 0);   // reset masks r3 hazard
    add(1, 1, 3, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 1, 3, 0, 0, 0, 0, 0,  1, 1, 0, 0);   // slots empty after reset
    add(0, 1, 0, 0, 3, 1, 0, 0,  1, 1, 0, 0);   // ADD r3
    add(0, 1, 3, 0, 5, 1, 0, 0,  0, 1, 1, 0);   // use r3: 3 stalls
    add(0, 1, 3, 0, 5, 1, 0, 0,  0, 1, 2, 0);
    add(0, 1, 3, 0, 5, 1, 0, 0,  0, 1, 3, 0);
    add(0, 1, 3, 0, 5, 1, 0, 0,  1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0);   // write r0: no slot
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 1, 0, 0, 2, 1, 0, 0,  1, 1, 0, 0);   // ADD r2
    add(0, 1, 0, 0, 2, 1, 0, 0,  1, 1, 0, 0);   // ADD r2
    add(0, 1, 2, 0, 0, 0, 0, 0,  0, 1, 1, 0);   // youngest wins
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 1, 0, 0, 2, 1, 0, 0,  1, 1, 0, 0);   // ADD r2
    add(0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);   // NOP
    add(0, 1, 2, 0, 0, 0, 0, 0,  0, 1, 2, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 1, 0, 0, 4, 1, 1, 0,  1, 1, 0, 0);   // LD r4
    add(0, 1, 0, 4, 0, 0, 0, 0,  0, 0, 0, 1);   // load-use stall
    add(0, 1, 0, 4, 0, 0, 0, 0,  0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 1, 0, 0, 3, 1, 0, 0,  1, 1, 0, 0);   // ADD r3
    add(0, 1, 3, 0, 6, 1, 0, 1,  1, 1, 1, 0);   // flush beats stall
    add(0, 1, 6, 0, 0, 0, 0, 0,  1, 1, 0, 0);   // r6 never allocated
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 1, 0, 0, 4, 1, 1, 0,  1, 1, 0, 0);   // LD r4
    add(0, 1, 0, 4, 0, 0, 0, 1,  1, 1, 0, 1);   // flush beats load-use

    foreach (tbl[n]) begin
      @(negedge clk);
      drive(tbl[n].rst, tbl[n].v, tbl[n].s1, tbl[n].s2, tbl[n].d, tbl[n].we, tbl[n].ld, tbl[n].fl);
      #1;
      chk($sformatf("vec%0d_stall_n_nofwd", n), 32'(sn[0]), 32'(tbl[n].e_sn0));
      chk($sformatf("vec%0d_stall_n_fwd", n), 32'(sn[1]), 32'(tbl[n].e_sn1));
      chk($sformatf("vec%0d_sel1_fwd", n), 32'(fs1[1]), 32'(tbl[n].e_f1));
      chk($sformatf("vec%0d_sel2_fwd", n), 32'(fs2[1]), 32'(tbl[n].e_f2));
      chk($sformatf("vec%0d_sel1_nofwd", n), 32'(fs1[0]), 32'd0);
      if (n == 4) begin
        chk("cnt_after_reset", 32'(cnt0), 32'd0);
        chk("cnt_after_reset_fwd", 32'(cnt1), 32'd0);
      end
      if (n == 10) chk("cnt_three_stalls", 32'(cnt0), 32'd3);
      model_check();
      @(posedge clk);
      model_update();
    end

    // Totals: stall-only took 7 stall cycles, forwarding 1, 2-bit counter pinned.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("cnt_total_nofwd", 32'(cnt0), 32'd7);
    chk("cnt_total_fwd", 32'(cnt1), 32'd1);
    chk("cnt_saturated", 32'(cnt2), 32'd3);
    model_check();
    @(posedge clk);
    model_update();

    // Random stream against the model.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 11) == 0);
      #1;
      model_check();
      @(posedge clk);
      model_update();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
